// File: rtl/warn_lamp_ctrl.sv
// Warning lamp controller: registered blue lamp, persistence-filtered red alarm with blink, ack and saturating alert count.
// Optional lamp test (ack held while IDLE lights both lamps) is enabled by defining WARN_LAMP_TEST_EN.
module warn_lamp_ctrl #(
  parameter int unsigned PERSIST   = 1000000,
  parameter int unsigned BLINK_DIV = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       warn_blue,
  input  logic       warn_red,
  input  logic       ack_btn,
  output logic       led_blue,
  output logic       led_red,
  output logic       buzzer,
  output logic [7:0] alert_count
);

  localparam int unsigned PW = $clog2(PERSIST + 1);
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [PW-1:0] P_MAX = PW'(PERSIST);
  localparam logic [BW-1:0] B_MAX = BW'(BLINK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALERT = 2'd1,
    ACKED = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   p_cnt_q, p_cnt_d;
  logic [BW-1:0]   blink_q, blink_d;
  logic            phase_q, phase_d;
  logic [2:0]      sync_q;
  logic [7:0]      cnt_q, cnt_d;
  logic            led_blue_q, led_blue_d;
  logic            led_red_q, led_red_d;
  logic            buzzer_q, buzzer_d;
  logic            red_valid;
  logic            ack_p;
  logic            lamp_test;

  // sync_q[0..1] is the two-flop synchroniser, sync_q[2] remembers the previous level for edge detection.
  assign red_valid = (p_cnt_q == P_MAX);
  assign ack_p     = sync_q[1] & ~sync_q[2];

  // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    p_cnt_d = '0;
    state_d = state_q;
    blink_d = '0;
    phase_d = 1'b0;
    cnt_d   = cnt_q;

    if (warn_red) p_cnt_d = red_valid ? p_cnt_q : p_cnt_q + PW'(1);

    unique case (state_q)
      IDLE:    if (red_valid) state_d = ALERT;
      ALERT:   if (ack_p) state_d = red_valid ? ACKED : IDLE;
      ACKED:   if (!red_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (state_d == ALERT) begin
      if (state_q != ALERT) begin
        phase_d = 1'b1;
      end else if (blink_q == B_MAX) begin
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + BW'(1);
        phase_d = phase_q;
      end
    end

    if (state_q == IDLE && state_d == ALERT && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
  end

  // Outputs are registered from next-state values so they change on the same edge as the state, glitch-free.
  always_comb begin
`ifdef WARN_LAMP_TEST_EN
    lamp_test = sync_q[0] && (state_d == IDLE);
`else
    lamp_test = 1'b0;
`endif
    led_blue_d = warn_blue | lamp_test;
    led_red_d  = ((state_d == ALERT) ? phase_d : (state_d == ACKED)) | lamp_test;
    buzzer_d   = (state_d == ALERT);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      p_cnt_q    <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b0;
      sync_q     <= '0;
      cnt_q      <= '0;
      led_blue_q <= 1'b0;
      led_red_q  <= 1'b0;
      buzzer_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      p_cnt_q    <= p_cnt_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      sync_q     <= {sync_q[1:0], ack_btn};
      cnt_q      <= cnt_d;
      led_blue_q <= led_blue_d;
      led_red_q  <= led_red_d;
      buzzer_q   <= buzzer_d;
    end
  end

  assign led_blue    = led_blue_q;
  assign led_red     = led_red_q;
  assign buzzer      = buzzer_q;
  assign alert_count = cnt_q;

endmodule

// File: tb/tb_warn_lamp_ctrl.sv
// Self-checking bench for warn_lamp_ctrl (PERSIST=3, BLINK_DIV=4) against an age/run-length reference model.
module tb_warn_lamp_ctrl;

  localparam int PERSIST   = 3;
  localparam int BLINK_DIV = 4;
  localparam int M_IDLE = 0, M_ALERT = 1, M_ACKED = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       warn_blue = 1'b0, warn_red = 1'b0, ack_btn = 1'b0;
  logic       led_blue, led_red, buzzer;
  logic [7:0] alert_count;

  int errors = 0;
  int checks = 0;

  // Reference model: red qualification by run length, blink by time spent in ALERT.
  int   m_run, m_mode, m_age, m_count;
  bit   m_a0, m_a1, m_a2;
  logic e_blue, e_red, e_buzz;
  logic [7:0] e_count;

  warn_lamp_ctrl #(.PERSIST(PERSIST), .BLINK_DIV(BLINK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .warn_blue(warn_blue), .warn_red(warn_red), .ack_btn(ack_btn),
    .led_blue(led_blue), .led_red(led_red), .buzzer(buzzer), .alert_count(alert_count)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_run = 0; m_mode = M_IDLE; m_age = 0; m_count = 0;
    m_a0 = 0; m_a1 = 0; m_a2 = 0;
    e_blue = 0; e_red = 0; e_buzz = 0; e_count = 0;
  endtask

  task automatic model_edge(input bit b, input bit r, input bit a);
    bit red_now, ackp_now;
    int nxt;
    red_now  = (m_run >= PERSIST);
    ackp_now = m_a1 && !m_a2;
    nxt = m_mode;
    if (m_mode == M_IDLE && red_now) nxt = M_ALERT;
    else if (m_mode == M_ALERT && ackp_now) nxt = red_now ? M_ACKED : M_IDLE;
    else if (m_mode == M_ACKED && !red_now) nxt = M_IDLE;
    if (nxt == M_ALERT && m_mode == M_IDLE) begin
      m_age = 0;
      if (m_count < 255) m_count++;
    end else if (nxt == M_ALERT) begin
      m_age++;
    end
    m_mode = nxt;
    m_run  = r ? ((m_run < 1000) ? m_run + 1 : m_run) : 0;
    m_a2 = m_a1; m_a1 = m_a0; m_a0 = a;
    e_blue  = b;
    e_buzz  = (m_mode == M_ALERT);
    e_red   = (m_mode == M_ALERT) ? (((m_age / BLINK_DIV) % 2) == 0) : (m_mode == M_ACKED);
`ifdef WARN_LAMP_TEST_EN
    if (m_a1 && m_mode == M_IDLE) begin
      e_blue = 1'b1;
      e_red  = 1'b1;
    end
`endif
    e_count = 8'(m_count);
  endtask

  // Inputs change on the falling edge; outputs are read back on the next falling edge.
  task automatic step(input bit b, input bit r, input bit a);
    warn_blue = b; warn_red = r; ack_btn = a;
    @(posedge clk);
    model_edge(b, r, a);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    warn_blue = 0; warn_red = 0; ack_btn = 0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (led_blue !== 1'b0) begin errors++; $display("FAIL reset_led_blue got=%b exp=0", led_blue); end
    checks++; if (led_red !== 1'b0) begin errors++; $display("FAIL reset_led_red got=%b exp=0", led_red); end
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL reset_buzzer got=%b exp=0", buzzer); end
    checks++; if (alert_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", alert_count); end
    rst_n = 1'b1;
  endtask

  task automatic test_blue();
    step(1, 0, 0);
    checks++; if (led_blue !== 1'b1) begin errors++; $display("FAIL blue_rise got=%b exp=1", led_blue); end
    step(1, 0, 0);
    checks++; if (led_blue !== 1'b1) begin errors++; $display("FAIL blue_hold got=%b exp=1", led_blue); end
    step(0, 0, 0);
    checks++; if (led_blue !== 1'b0) begin errors++; $display("FAIL blue_fall got=%b exp=0", led_blue); end
  endtask

  task automatic test_filter();
    bit pat [5] = '{1, 1, 0, 0, 0};
    for (int i = 0; i < 5; i++) begin
      step(0, pat[i], 0);
      checks++;
      if (led_red !== 1'b0 || buzzer !== 1'b0 || alert_count !== 8'd0) begin
        errors++;
        $display("FAIL filter_short_pulse step=%0d got red=%b buz=%b cnt=%0d exp 0/0/0", i, led_red, buzzer, alert_count);
      end
    end
  endtask

  task automatic test_alert_blink();
    bit pat [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    for (int i = 0; i < PERSIST; i++) step(0, 1, 0);
    checks++; if (buzzer !== 1'b0) begin errors++; $display("FAIL alert_early got=%b exp=0", buzzer); end
    for (int i = 0; i < 9; i++) begin
      step(0, 1, 0);
      checks++;
      if (led_red !== pat[i] || buzzer !== 1'b1) begin
        errors++;
        $display("FAIL alert_blink idx=%0d got red=%b buz=%b exp red=%b buz=1", i, led_red, buzzer, pat[i]);
      end
    end
    checks++; if (alert_count !== 8'd1) begin errors++; $display("FAIL alert_count got=%0d exp=1", alert_count); end
  endtask

  task automatic test_ack();
    bit got = 0;
    step(0, 1, 1);
    for (int i = 0; i < 3 && !got; i++) begin
      step(0, 1, 0);
      got = (buzzer === 1'b0);
    end
    checks++; if (!got) begin errors++; $display("FAIL ack_timeout buzzer=%b exp=0 within 3 edges", buzzer); end
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0);
      checks++;
      if (led_red !== 1'b1 || buzzer !== 1'b0) begin
        errors++;
        $display("FAIL acked_solid idx=%0d got red=%b buz=%b exp 1/0", i, led_red, buzzer);
      end
    end
    step(0, 0, 0);
    step(0, 0, 0);
    checks++;
    if (led_red !== 1'b0 || buzzer !== 1'b0 || alert_count !== 8'd1) begin
      errors++;
      $display("FAIL ack_release got red=%b buz=%b cnt=%0d exp 0/0/1", led_red, buzzer, alert_count);
    end
  endtask

  task automatic test_hold_ack();
    repeat (4) step(0, 0, 1);
    for (int i = 0; i < PERSIST + 1 + 10; i++) begin
      step(0, 1, 1);
      checks++;
      if (led_red !== e_red || led_blue !== e_blue) begin
        errors++;
        $display("FAIL hold_ack_leds idx=%0d got red=%b blue=%b exp red=%b blue=%b", i, led_red, led_blue, e_red, e_blue);
      end
    end
    checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL hold_ack_single_pulse buzzer=%b exp=1", buzzer); end
    repeat (2) step(0, 1, 0);
    step(0, 1, 1);
    repeat (3) step(0, 1, 0);
    checks++; if (buzzer !== 1'b0 || led_red !== 1'b1) begin errors++; $display("FAIL hold_ack_acked got buz=%b red=%b exp 0/1", buzzer, led_red); end
    repeat (2) step(0, 0, 0);
  endtask

  task automatic test_latched();
    logic [7:0] saved;
    for (int i = 0; i < PERSIST + 1; i++) step(0, 1, 0);
    saved = alert_count;
    checks++; if (saved !== e_count) begin errors++; $display("FAIL latched_count got=%0d exp=%0d", saved, e_count); end
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0);
      checks++;
      if (buzzer !== 1'b1 || led_red !== e_red) begin
        errors++;
        $display("FAIL latched_alert idx=%0d got buz=%b red=%b exp buz=1 red=%b", i, buzzer, led_red, e_red);
      end
    end
    step(0, 0, 1);
    repeat (3) step(0, 0, 0);
    checks++;
    if (buzzer !== 1'b0 || led_red !== 1'b0 || alert_count !== saved) begin
      errors++;
      $display("FAIL latched_ack_idle got buz=%b red=%b cnt=%0d exp 0/0/%0d", buzzer, led_red, alert_count, saved);
    end
  endtask

  task automatic test_random();
    bit b, r, a;
    r = 0; a = 0;
    for (int i = 0; i < 600; i++) begin
      b = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) r = ~r;
      if ($urandom_range(0, 7) == 0) a = ~a;
      step(b, r, a);
      checks++;
      if (led_blue !== e_blue || led_red !== e_red || buzzer !== e_buzz || alert_count !== e_count) begin
        errors++;
        $display("FAIL random cyc=%0d got blue=%b red=%b buz=%b cnt=%0d exp blue=%b red=%b buz=%b cnt=%0d",
                 i, led_blue, led_red, buzzer, alert_count, e_blue, e_red, e_buzz, e_count);
      end
    end
    repeat (3) step(0, 0, 0);
    step(0, 0, 1);
    repeat (4) step(0, 0, 0);
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 256; n++) begin
      for (int i = 0; i < PERSIST + 1; i++) step(0, 1, 0);
      step(0, 1, 1);
      repeat (3) step(0, 1, 0);
      repeat (2) step(0, 0, 0);
      checks++;
      if (alert_count !== e_count || buzzer !== 1'b0) begin
        errors++;
        $display("FAIL saturation iter=%0d got cnt=%0d buz=%b exp cnt=%0d buz=0", n, alert_count, buzzer, e_count);
      end
    end
    checks++; if (alert_count !== 8'd255) begin errors++; $display("FAIL saturation_final got=%0d exp=255", alert_count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < PERSIST + 2; i++) step(1, 1, 0);
    checks++; if (buzzer !== 1'b1) begin errors++; $display("FAIL async_pre_alert buzzer=%b exp=1", buzzer); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led_blue !== 1'b0 || led_red !== 1'b0 || buzzer !== 1'b0 || alert_count !== 8'd0) begin
      errors++;
      $display("FAIL async_reset got blue=%b red=%b buz=%b cnt=%0d exp all 0", led_blue, led_red, buzzer, alert_count);
    end
    model_reset();
    warn_blue = 0; warn_red = 0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < PERSIST + 1; i++) step(0, 1, 0);
    checks++; if (alert_count !== 8'd1) begin errors++; $display("FAIL async_requalify got=%0d exp=1", alert_count); end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_blue();
    test_filter();
    test_alert_blink();
    test_ack();
    test_hold_ack();
    test_latched();
    do_reset();
    test_random();
    do_reset();
    test_saturation();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
